// File: rtl/board_engine.sv
// 2048 game-logic engine: owns the 4x4 board, runs one slide/merge per move, spawns tiles, flags game-over.
// Optional one-deep undo snapshot is built when BOARD_UNDO_EN is defined.
module board_engine #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [63:0] INIT_BOARD = 64'h0000_0000_0001_0001,
  parameter int          SCORE_W    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  output logic               move_ready,
  input  logic               new_game,
  input  logic               undo,
  output logic [63:0]        board_state,
  output logic [SCORE_W-1:0] score,
  output logic               moved,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE, PROC, SPAWN, CHECK} state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  state_t             state_reg;
  logic [1:0]         dir_reg;
  logic [1:0]         line_reg;
  logic [1:0]         spawn_cnt_reg;
  logic [3:0]         idx_reg;
  logic [15:0]        lfsr_reg;
  logic [63:0]        work_reg;
  logic [63:0]        board_reg;
  logic [SCORE_W-1:0] pending_reg;
  logic [SCORE_W-1:0] score_reg;
  logic               changed_reg;
  logic               new_game_reg;
  logic               moved_reg;
  logic               game_over_reg;

`ifdef BOARD_UNDO_EN
  logic [63:0]        snap_board_reg;
  logic [SCORE_W-1:0] snap_score_reg;
  logic               snap_valid_reg;
`else
  logic               unused_undo;
  assign unused_undo = undo;
`endif

  logic lfsr_fb;
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // Board cell for position j (0 = edge the tiles move toward) of line k.
  function automatic logic [3:0] cell_of(input logic [1:0] d, input logic [1:0] k,
                                         input logic [1:0] j);
    case (d)
      DIR_UP:    cell_of = {j, k};
      DIR_DOWN:  cell_of = {~j, k};
      DIR_LEFT:  cell_of = {k, j};
      DIR_RIGHT: cell_of = {k, ~j};
      default:   cell_of = 4'd0;
    endcase
  endfunction

  logic [3:0] wcell [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_cell
    assign wcell[gi] = work_reg[4*gi +: 4];
  end

  logic [3:0]         line_in   [4];
  logic [3:0]         comp      [5];
  logic [3:0]         line_out  [4];
  logic [2:0]         comp_cnt;
  logic [2:0]         out_cnt;
  logic               skip;
  logic [SCORE_W:0]   gain_bit;
  logic [SCORE_W:0]   gain_sum;
  logic [SCORE_W-1:0] line_gain;
  logic               line_diff;
  logic [63:0]        work_line_next;
  logic [SCORE_W:0]   pending_sum;
  logic [SCORE_W-1:0] pending_next;

  // One line per cycle: compress toward the front, then merge pairs front-to-back.
  always_comb begin
    comp_cnt       = 3'd0;
    out_cnt        = 3'd0;
    skip           = 1'b0;
    gain_bit       = '0;
    gain_sum       = '0;
    line_gain      = '0;
    line_diff      = 1'b0;
    work_line_next = work_reg;
    for (int j = 0; j < 5; j++) comp[j] = 4'd0;
    for (int j = 0; j < 4; j++) begin
      line_in[j]  = wcell[cell_of(dir_reg, line_reg, 2'(j))];
      line_out[j] = 4'd0;
    end
    for (int j = 0; j < 4; j++) begin
      if (line_in[j] != 4'd0) begin
        comp[comp_cnt] = line_in[j];
        comp_cnt       = comp_cnt + 3'd1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[j] != 4'd0) begin
        if (comp[j] == comp[j+1]) begin
          line_out[out_cnt[1:0]] = (comp[j] == 4'hF) ? 4'hF : comp[j] + 4'd1;
          gain_bit  = {{SCORE_W{1'b0}}, 1'b1} << ({1'b0, comp[j]} + 5'd1);
          gain_sum  = {1'b0, line_gain} + gain_bit;
          line_gain = gain_sum[SCORE_W] ? '1 : gain_sum[SCORE_W-1:0];
          skip      = 1'b1;
        end else begin
          line_out[out_cnt[1:0]] = comp[j];
        end
        out_cnt = out_cnt + 3'd1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (line_out[j] != line_in[j]) line_diff = 1'b1;
      work_line_next[4*cell_of(dir_reg, line_reg, 2'(j)) +: 4] = line_out[j];
    end
    pending_sum  = {1'b0, pending_reg} + {1'b0, line_gain};
    pending_next = pending_sum[SCORE_W] ? '1 : pending_sum[SCORE_W-1:0];
  end

  logic stuck;
  always_comb begin
    stuck = 1'b1;
    for (int i = 0; i < 16; i++)
      if (wcell[i] == 4'd0) stuck = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (wcell[r*4+c] == wcell[r*4+c+1]) stuck = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (wcell[r*4+c] == wcell[r*4+c+4]) stuck = 1'b0;
  end

  assign move_ready  = (state_reg == IDLE) && !game_over_reg;
  assign board_state = board_reg;
  assign score       = score_reg;
  assign moved       = moved_reg;
  assign game_over   = game_over_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      dir_reg        <= 2'd0;
      line_reg       <= 2'd0;
      spawn_cnt_reg  <= 2'd0;
      idx_reg        <= 4'd0;
      lfsr_reg       <= LFSR_SEED;
      work_reg       <= INIT_BOARD;
      board_reg      <= INIT_BOARD;
      pending_reg    <= '0;
      score_reg      <= '0;
      changed_reg    <= 1'b0;
      new_game_reg   <= 1'b0;
      moved_reg      <= 1'b0;
      game_over_reg  <= 1'b0;
`ifdef BOARD_UNDO_EN
      snap_board_reg <= '0;
      snap_score_reg <= '0;
      snap_valid_reg <= 1'b0;
`endif
    end else begin
      lfsr_reg  <= {lfsr_reg[14:0], lfsr_fb};
      moved_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (new_game) begin
            work_reg      <= '0;
            spawn_cnt_reg <= 2'd2;
            idx_reg       <= lfsr_reg[3:0];
            pending_reg   <= '0;
            new_game_reg  <= 1'b1;
            state_reg     <= SPAWN;
          end
`ifdef BOARD_UNDO_EN
          else if (undo && snap_valid_reg) begin
            board_reg      <= snap_board_reg;
            score_reg      <= snap_score_reg;
            snap_valid_reg <= 1'b0;
            game_over_reg  <= 1'b0;
          end
`endif
          else if (move_valid && move_ready) begin
            dir_reg      <= move_dir;
            work_reg     <= board_reg;
            changed_reg  <= 1'b0;
            line_reg     <= 2'd0;
            pending_reg  <= '0;
            new_game_reg <= 1'b0;
            state_reg    <= PROC;
          end
        end
        PROC: begin
          work_reg    <= work_line_next;
          pending_reg <= pending_next;
          changed_reg <= changed_reg | line_diff;
          line_reg    <= line_reg + 2'd1;
          if (line_reg == 2'd3) begin
            if (changed_reg || line_diff) begin
              spawn_cnt_reg <= 2'd1;
              idx_reg       <= lfsr_reg[3:0];
              state_reg     <= SPAWN;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        SPAWN: begin
          // Linear probe from a random start; an empty cell always exists here.
          if (wcell[idx_reg] == 4'd0) begin
            work_reg[4*idx_reg +: 4] <= (lfsr_reg[7:4] == 4'd0) ? 4'd2 : 4'd1;
            spawn_cnt_reg <= spawn_cnt_reg - 2'd1;
            idx_reg       <= lfsr_reg[3:0];
            if (spawn_cnt_reg == 2'd1) state_reg <= CHECK;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end
        CHECK: begin
          board_reg     <= work_reg;
          score_reg     <= new_game_reg ? '0 : score_reg + pending_reg;
          game_over_reg <= stuck;
          moved_reg     <= !new_game_reg;
`ifdef BOARD_UNDO_EN
          if (new_game_reg) begin
            snap_valid_reg <= 1'b0;
          end else begin
            snap_board_reg <= board_reg;
            snap_score_reg <= score_reg;
            snap_valid_reg <= 1'b1;
          end
`endif
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_engine.sv
// Self-checking bench for board_engine: random play against a queue-based 2048 reference model.
module tb_board_engine;
  localparam logic [63:0] INIT = 64'h0000_0000_0001_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        new_game = 1'b0;
  logic        undo = 1'b0;
  logic        move_ready;
  logic [63:0] board_state;
  logic [19:0] score;
  logic        moved;
  logic        game_over;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_board;
  logic [19:0] m_score;

  board_engine dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .new_game(new_game), .undo(undo),
    .board_state(board_state), .score(score), .moved(moved), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int get_cell(input logic [63:0] b, input int r, input int c);
    return int'(b[(r*4+c)*4 +: 4]);
  endfunction

  function automatic void line_pos(input int d, input int k, input int s, output int r, output int c);
    case (d)
      0: begin r = s;     c = k;     end
      1: begin r = 3 - s; c = k;     end
      2: begin r = k;     c = s;     end
      default: begin r = k; c = 3 - s; end
    endcase
  endfunction

  function automatic void slide(input logic [63:0] b, input int d, output logic [63:0] nb,
                                output int unsigned gain);
    int q[$];
    int res[$];
    int r, c;
    nb = '0;
    gain = 0;
    for (int k = 0; k < 4; k++) begin
      q.delete();
      res.delete();
      for (int s = 0; s < 4; s++) begin
        line_pos(d, k, s, r, c);
        if (get_cell(b, r, c) != 0) q.push_back(get_cell(b, r, c));
      end
      while (q.size() > 0) begin
        if (q.size() > 1 && q[0] == q[1]) begin
          gain += 1 << (q[0] + 1);
          res.push_back(q[0] == 15 ? 15 : q[0] + 1);
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          res.push_back(q.pop_front());
        end
      end
      for (int s = 0; s < res.size(); s++) begin
        line_pos(d, k, s, r, c);
        nb[(r*4+c)*4 +: 4] = 4'(res[s]);
      end
    end
  endfunction

  function automatic bit stuck(input logic [63:0] b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (get_cell(b, r, c) == 0) return 1'b0;
        if (c < 3 && get_cell(b, r, c) == get_cell(b, r, c+1)) return 1'b0;
        if (r < 3 && get_cell(b, r, c) == get_cell(b, r+1, c)) return 1'b0;
      end
    return 1'b1;
  endfunction

  // Exactly one previously empty cell now holds a 1 or a 2.
  function automatic bit spawn_ok(input logic [63:0] slid, input logic [63:0] act);
    int nd = 0;
    bit ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (slid[i*4 +: 4] != act[i*4 +: 4]) begin
        nd++;
        if (slid[i*4 +: 4] != 4'd0 || act[i*4 +: 4] == 4'd0 || act[i*4 +: 4] > 4'd2) ok = 1'b0;
      end
    return ok && (nd == 1);
  endfunction

  function automatic int count_nz(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[i*4 +: 4] != 4'd0) n++;
    return n;
  endfunction

  function automatic int max_val(input logic [63:0] b);
    int m = 0;
    for (int i = 0; i < 16; i++) if (int'(b[i*4 +: 4]) > m) m = int'(b[i*4 +: 4]);
    return m;
  endfunction

  function automatic int pick_changing_dir(input logic [63:0] b);
    logic [63:0] nb;
    int unsigned g;
    for (int d = 0; d < 4; d++) begin
      slide(b, d, nb, g);
      if (nb != b) return d;
    end
    return 0;
  endfunction

  // ---------------- stimulus drivers (no comparisons) ----------------
  task automatic apply_reset();
    rst = 1'b0; move_valid = 1'b0; new_game = 1'b0; undo = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_board = INIT;
    m_score = '0;
  endtask

  task automatic issue_move(input int d, input bit poke_busy, output int lat, output int pulses,
                            output int partial);
    lat = -1; pulses = 0; partial = 0;
    @(negedge clk);
    move_valid = 1'b1;
    move_dir = 2'(d);
    @(negedge clk);
    move_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (moved) begin
        pulses++;
        if (lat < 0) lat = n;
      end else if (board_state !== m_board) begin
        partial++;
      end
      if (poke_busy && n == 1) begin move_valid = 1'b1; move_dir = ~2'(d); end
      if (n == 2) move_valid = 1'b0;
      if (moved || (move_ready && n >= 4)) break;
    end
    move_valid = 1'b0;
    @(posedge clk); #1;
    if (moved) pulses++;
    $display("move dir=%0d lat=%0d pulses=%0d score=%0d board=%h", d, lat, pulses, score, board_state);
  endtask

  task automatic do_new_game(output int cyc, output int mv);
    cyc = 0; mv = 0;
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (moved) mv++;
      if (move_ready) begin cyc = n; break; end
    end
    @(posedge clk); #1;
    if (moved) mv++;
    $display("new_game cycles=%0d board=%h", cyc, board_state);
  endtask

  task automatic pulse_undo();
    @(negedge clk); undo = 1'b1;
    @(negedge clk); undo = 1'b0;
    @(posedge clk); #1;
    $display("undo score=%0d board=%h", score, board_state);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (board_state !== INIT) begin errors++; $display("FAIL reset_board: got %h want %h", board_state, INIT); end
    checks++; if (score !== 20'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", move_ready); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b want 0", moved); end
    @(negedge clk); rst = 1'b1;
    m_board = INIT; m_score = '0;
  endtask

  task automatic test_first_move();
    logic [63:0] slid;
    int unsigned gain;
    int lat, p, part;
    slide(m_board, 0, slid, gain);
    issue_move(0, 1'b0, lat, p, part);
    checks++; if (p !== 1) begin errors++; $display("FAIL first_moved_pulses: got %0d want 1", p); end
    checks++; if (lat < 6 || lat > 21) begin errors++; $display("FAIL first_latency: got %0d want 6..21", lat); end
    checks++; if (part !== 0) begin errors++; $display("FAIL first_partial: got %0d want 0", part); end
    checks++; if (score !== 20'd4) begin errors++; $display("FAIL first_score: got %0d want 4", score); end
    checks++; if (board_state[3:0] !== 4'd2) begin errors++; $display("FAIL first_cell0: got %0d want 2", board_state[3:0]); end
    checks++; if (spawn_ok(slid, board_state) !== 1'b1) begin errors++; $display("FAIL first_spawn: got %h want %h plus one tile", board_state, slid); end
    m_board = board_state;
    m_score = m_score + 20'(gain);
  endtask

  task automatic test_no_change();
    int lat, p, part;
    apply_reset();
    issue_move(2, 1'b0, lat, p, part);
    checks++; if (p !== 0) begin errors++; $display("FAIL nochange_moved: got %0d want 0", p); end
    checks++; if (board_state !== INIT) begin errors++; $display("FAIL nochange_board: got %h want %h", board_state, INIT); end
    checks++; if (score !== 20'd0) begin errors++; $display("FAIL nochange_score: got %0d want 0", score); end
    checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL nochange_ready: got %b want 1", move_ready); end
  endtask

  task automatic test_reset_mid_move();
    logic [63:0] slid;
    int unsigned gain;
    int lat, p, part;
    @(negedge clk); move_valid = 1'b1; move_dir = 2'd3;
    @(negedge clk); move_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (board_state !== INIT) begin errors++; $display("FAIL midrst_board: got %h want %h", board_state, INIT); end
    checks++; if (score !== 20'd0) begin errors++; $display("FAIL midrst_score: got %0d want 0", score); end
    checks++; if (move_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", move_ready); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL midrst_moved: got %b want 0", moved); end
    @(negedge clk); rst = 1'b1;
    m_board = INIT; m_score = '0;
    slide(m_board, 1, slid, gain);
    issue_move(1, 1'b0, lat, p, part);
    checks++; if (p !== 1) begin errors++; $display("FAIL midrst_next_pulses: got %0d want 1", p); end
    checks++; if (score !== 20'd4) begin errors++; $display("FAIL midrst_next_score: got %0d want 4", score); end
    checks++; if (spawn_ok(slid, board_state) !== 1'b1) begin errors++; $display("FAIL midrst_next_spawn: got %h want %h plus one tile", board_state, slid); end
    m_board = board_state;
    m_score = m_score + 20'(gain);
  endtask

  task automatic test_busy_ignore();
    logic [63:0] slid;
    int unsigned gain;
    int lat, p, part, d, extra;
    d = pick_changing_dir(m_board);
    slide(m_board, d, slid, gain);
    issue_move(d, 1'b1, lat, p, part);
    checks++; if (p !== 1) begin errors++; $display("FAIL busy_pulses: got %0d want 1", p); end
    checks++; if (score !== m_score + 20'(gain)) begin errors++; $display("FAIL busy_score: got %0d want %0d", score, m_score + 20'(gain)); end
    checks++; if (spawn_ok(slid, board_state) !== 1'b1) begin errors++; $display("FAIL busy_spawn: got %h want %h plus one tile", board_state, slid); end
    m_board = board_state;
    m_score = m_score + 20'(gain);
    extra = 0;
    repeat (25) begin @(posedge clk); #1; if (moved) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_queued_move: got %0d pulses want 0", extra); end
    checks++; if (board_state !== m_board) begin errors++; $display("FAIL busy_board: got %h want %h", board_state, m_board); end
  endtask

  task automatic test_undo();
    logic [63:0] slid, pre_b;
    logic [19:0] pre_s;
    int unsigned gain;
    int lat, p, part, d;
    d = pick_changing_dir(m_board);
    pre_b = m_board;
    pre_s = m_score;
    slide(m_board, d, slid, gain);
    issue_move(d, 1'b0, lat, p, part);
    checks++; if (spawn_ok(slid, board_state) !== 1'b1) begin errors++; $display("FAIL undo_move_spawn: got %h want %h plus one tile", board_state, slid); end
    m_board = board_state;
    m_score = m_score + 20'(gain);
`ifdef BOARD_UNDO_EN
    pulse_undo();
    checks++; if (board_state !== pre_b) begin errors++; $display("FAIL undo_board: got %h want %h", board_state, pre_b); end
    checks++; if (score !== pre_s) begin errors++; $display("FAIL undo_score: got %0d want %0d", score, pre_s); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL undo_game_over: got %b want 0", game_over); end
    m_board = pre_b;
    m_score = pre_s;
    pulse_undo();
    checks++; if (board_state !== m_board) begin errors++; $display("FAIL undo2_board: got %h want %h", board_state, m_board); end
    checks++; if (score !== m_score) begin errors++; $display("FAIL undo2_score: got %0d want %0d", score, m_score); end
`else
    pulse_undo();
    checks++; if (board_state !== m_board) begin errors++; $display("FAIL undo_ignored_board: got %h want %h (pre %h)", board_state, m_board, pre_b); end
    checks++; if (score !== m_score) begin errors++; $display("FAIL undo_ignored_score: got %0d want %0d (pre %0d)", score, m_score, pre_s); end
`endif
  endtask

  task automatic test_random_play();
    logic [63:0] slid;
    int unsigned gain;
    int lat, p, part, d, cyc, mv;
    do_new_game(cyc, mv);
    checks++; if (cyc < 3 || cyc > 33) begin errors++; $display("FAIL ng_latency: got %0d want 3..33", cyc); end
    checks++; if (mv !== 0) begin errors++; $display("FAIL ng_moved: got %0d want 0", mv); end
    checks++; if (score !== 20'd0) begin errors++; $display("FAIL ng_score: got %0d want 0", score); end
    checks++; if (count_nz(board_state) !== 2) begin errors++; $display("FAIL ng_tiles: got %0d want 2", count_nz(board_state)); end
    checks++; if (max_val(board_state) > 2) begin errors++; $display("FAIL ng_values: got max %0d want <=2", max_val(board_state)); end
    m_board = board_state;
    m_score = '0;
    for (int i = 0; i < 2000 && !game_over; i++) begin
      d = int'($urandom_range(0, 3));
      slide(m_board, d, slid, gain);
      issue_move(d, 1'b0, lat, p, part);
      if (slid != m_board) begin
        checks++; if (p !== 1) begin errors++; $display("FAIL rnd_pulses: got %0d want 1", p); end
        checks++; if (lat < 6 || lat > 21) begin errors++; $display("FAIL rnd_latency: got %0d want 6..21", lat); end
        checks++; if (part !== 0) begin errors++; $display("FAIL rnd_partial: got %0d want 0", part); end
        checks++; if (score !== m_score + 20'(gain)) begin errors++; $display("FAIL rnd_score: got %0d want %0d", score, m_score + 20'(gain)); end
        checks++; if (spawn_ok(slid, board_state) !== 1'b1) begin errors++; $display("FAIL rnd_spawn: got %h want %h plus one tile", board_state, slid); end
        m_board = board_state;
        m_score = m_score + 20'(gain);
        checks++; if (game_over !== stuck(m_board)) begin errors++; $display("FAIL rnd_game_over: got %b want %b", game_over, stuck(m_board)); end
      end else begin
        checks++; if (p !== 0) begin errors++; $display("FAIL rnd_nochange_pulses: got %0d want 0", p); end
        checks++; if (board_state !== m_board) begin errors++; $display("FAIL rnd_nochange_board: got %h want %h", board_state, m_board); end
        checks++; if (score !== m_score) begin errors++; $display("FAIL rnd_nochange_score: got %0d want %0d", score, m_score); end
      end
    end
  endtask

  task automatic test_game_over();
    int lat, p, part, cyc, mv;
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_reached: got %b want 1", game_over); end
    checks++; if (move_ready !== 1'b0) begin errors++; $display("FAIL go_ready: got %b want 0", move_ready); end
    for (int d = 0; d < 4; d++) begin
      issue_move(d, 1'b0, lat, p, part);
      checks++; if (p !== 0 || part !== 0) begin errors++; $display("FAIL go_ignored: got pulses=%0d changes=%0d want 0/0", p, part); end
      checks++; if (score !== m_score) begin errors++; $display("FAIL go_score: got %0d want %0d", score, m_score); end
    end
    do_new_game(cyc, mv);
    checks++; if (cyc < 3 || cyc > 33) begin errors++; $display("FAIL go_ng_latency: got %0d want 3..33", cyc); end
    checks++; if (mv !== 0) begin errors++; $display("FAIL go_ng_moved: got %0d want 0", mv); end
    checks++; if (score !== 20'd0) begin errors++; $display("FAIL go_ng_score: got %0d want 0", score); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL go_ng_cleared: got %b want 0", game_over); end
    checks++; if (count_nz(board_state) !== 2) begin errors++; $display("FAIL go_ng_tiles: got %0d want 2", count_nz(board_state)); end
    checks++; if (max_val(board_state) > 2) begin errors++; $display("FAIL go_ng_values: got max %0d want <=2", max_val(board_state)); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_no_change();
    test_reset_mid_move();
    test_busy_ignore();
    test_undo();
    test_random_play();
    test_game_over();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
